ffn_residual_add: RTL and testbench

//  Residual (skip) adder directly downstream of the FFN stage: out = x + FFN(x), per element.

---
 rtl/transformer_pkg.sv | 33 +++
 rtl/resid_row_add.sv | 14 +
 rtl/ffn_residual_add.sv | 107 ++++++++++
 tb/tb_ffn_residual_add.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/transformer_pkg.sv
// Shared transformer types, tensor geometry and the residual element adder.
// Build option: define RESID_SAT_EN to clamp residual sums instead of wrapping.
package transformer_pkg;

  localparam int SEQ    = 8;
  localparam int EMB    = 64;
  localparam int DATA_W = 16;
  localparam int CNT_W  = (SEQ > 1) ? $clog2(SEQ) : 1;

  typedef logic [DATA_W-1:0]  elem_t;
  typedef elem_t [EMB-1:0]    emb_row_t;
  typedef emb_row_t [SEQ-1:0] seq_emb_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_FFN = 2'd1,
    S_ADD      = 2'd2
  } resid_state_e;

  // One extra bit holds the exact signed sum; overflow shows as sign/MSB disagreement.
  function automatic elem_t sat_add(input elem_t a, input elem_t b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
`ifdef RESID_SAT_EN
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
`else
    return s[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/resid_row_add.sv
// Combinational EMB-wide row adder: one sat_add lane per embedding element.
module resid_row_add
  import transformer_pkg::*;
(
  input  emb_row_t i_a,
  input  emb_row_t i_b,
  output emb_row_t o_sum
);

  for (genvar e = 0; e < EMB; e++) begin : g_lane
    assign o_sum[e] = sat_add(i_a[e], i_b[e]);
  end

endmodule

// File: rtl/ffn_residual_add.sv
// Residual adder after the FFN: holds skip tensor x, waits for FFN(x), adds one row per cycle.
// Build option: RESID_SAT_EN selects saturating sums (see transformer_pkg::sat_add).
module ffn_residual_add
  import transformer_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     skip_valid,
  input  seq_emb_t skip_seq,
  input  logic     ffn_valid,
  input  seq_emb_t ffn_seq,
  output logic     valid_out,
  output seq_emb_t out_seq,
  output logic     busy,
  output logic     err_overrun,
  output logic     err_orphan
);

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(SEQ - 1);

  resid_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_row_cnt;
  seq_emb_t         r_skip, r_ffn, r_out;
  logic             r_valid_out, r_err_overrun, r_err_orphan;

  logic     w_latch_skip, w_latch_ffn, w_row_we, w_done, w_ovr, w_orph;
  emb_row_t w_sum_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (skip_valid) w_state_nxt = ffn_valid ? S_ADD : S_WAIT_FFN;
      S_WAIT_FFN: if (ffn_valid) w_state_nxt = S_ADD;
      S_ADD:      if (r_row_cnt == LAST_ROW) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Inputs arriving while a transaction is in flight are flagged and dropped.
  always_comb begin
    w_latch_skip = 1'b0;
    w_latch_ffn  = 1'b0;
    w_row_we     = 1'b0;
    w_done       = 1'b0;
    w_ovr        = 1'b0;
    w_orph       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_latch_skip = skip_valid;
        w_latch_ffn  = skip_valid & ffn_valid;
        w_orph       = ffn_valid & ~skip_valid;
      end
      S_WAIT_FFN: begin
        w_latch_ffn = ffn_valid;
        w_ovr       = skip_valid;
      end
      S_ADD: begin
        w_row_we = 1'b1;
        w_done   = (r_row_cnt == LAST_ROW);
        w_ovr    = skip_valid;
        w_orph   = ffn_valid;
      end
      default: ;
    endcase
  end

  resid_row_add u_row_add (
    .i_a   (r_skip[r_row_cnt]),
    .i_b   (r_ffn[r_row_cnt]),
    .o_sum (w_sum_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt     <= '0;
      r_skip        <= '0;
      r_ffn         <= '0;
      r_out         <= '0;
      r_valid_out   <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_orphan  <= 1'b0;
    end else begin
      r_valid_out   <= w_done;
      r_err_overrun <= w_ovr;
      r_err_orphan  <= w_orph;
      if (w_latch_skip) r_skip <= skip_seq;
      if (w_latch_ffn)  r_ffn  <= ffn_seq;
      // Counter parks on the last row; only a fresh ADD entry rewinds it.
      if (w_latch_ffn)             r_row_cnt <= '0;
      else if (w_row_we && !w_done) r_row_cnt <= r_row_cnt + 1'b1;
      for (int t = 0; t < SEQ; t++)
        if (w_row_we && r_row_cnt == CNT_W'(t)) r_out[t] <= w_sum_row;
    end
  end

  assign valid_out   = r_valid_out;
  assign out_seq     = r_out;
  assign busy        = (r_state != S_IDLE);
  assign err_overrun = r_err_overrun;
  assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_ffn_residual_add.sv
// Scoreboard bench for ffn_residual_add: stimulus pushes expected sums, a monitor pops on valid_out.
module tb_ffn_residual_add;
  import transformer_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     skip_valid, ffn_valid;
  seq_emb_t skip_seq, ffn_seq;
  logic     valid_out, busy, err_overrun, err_orphan;
  seq_emb_t out_seq;

  ffn_residual_add dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .skip_valid  (skip_valid),
    .skip_seq    (skip_seq),
    .ffn_valid   (ffn_valid),
    .ffn_seq     (ffn_seq),
    .valid_out   (valid_out),
    .out_seq     (out_seq),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    seq_emb_t d;
    int       cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_ex;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   orphan_cnt = 0, overrun_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer sum, then clamp or keep the low DATA_W bits.
  function automatic seq_emb_t ref_sum(input seq_emb_t x, input seq_emb_t f);
    seq_emb_t r;
    int a, b, s;
    for (int t = 0; t < SEQ; t++)
      for (int e = 0; e < EMB; e++) begin
        a = $signed(x[t][e]);
        b = $signed(f[t][e]);
        s = a + b;
`ifdef RESID_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        r[t][e] = s[DATA_W-1:0];
      end
    return r;
  endfunction

  function automatic seq_emb_t fill(input elem_t v);
    seq_emb_t r;
    for (int t = 0; t < SEQ; t++)
      for (int e = 0; e < EMB; e++) r[t][e] = v;
    return r;
  endfunction

  function automatic seq_emb_t rnd();
    seq_emb_t r;
    for (int t = 0; t < SEQ; t++)
      for (int e = 0; e < EMB; e++)
        case ($urandom_range(0, 3))
          0:       r[t][e] = 16'h7FFF;
          1:       r[t][e] = 16'h8000;
          default: r[t][e] = DATA_W'($urandom);
        endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_t(input string nm, input seq_emb_t act, input seq_emb_t exp);
    int bt, be;
    bt = -1; be = -1;
    for (int t = 0; t < SEQ; t++)
      for (int e = 0; e < EMB; e++)
        if (bt < 0 && act[t][e] !== exp[t][e]) begin bt = t; be = e; end
    n_chk++;
    if (bt >= 0) begin
      n_fail++;
      $display("FAIL %s: row %0d elem %0d got %h expected %h", nm, bt, be,
               act[bt][be], exp[bt][be]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_orphan)  orphan_cnt++;
      if (err_overrun) overrun_cnt++;
      if (valid_out) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid_out: got pulse at cycle %0d expected none", cyc);
        end else begin
          mon_ex = q.pop_front();
          chk_t("result", out_seq, mon_ex.d);
          chk("valid_out_cycle", cyc, mon_ex.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gap==0: skip and ffn in the same cycle; otherwise ffn follows gap cycles later.
  task automatic txn(input seq_emb_t x, input seq_emb_t f, input int gap, input bit expect_done);
    int c;
    c = 0;
    step();
    skip_seq = x; skip_valid = 1'b1;
    if (gap == 0) begin ffn_seq = f; ffn_valid = 1'b1; c = cyc; end
    step();
    skip_valid = 1'b0; ffn_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap - 1) step();
      ffn_seq = f; ffn_valid = 1'b1; c = cyc;
      step();
      ffn_valid = 1'b0;
    end
    if (expect_done) q.push_back('{ref_sum(x, f), c + SEQ + 1});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin step(); n++; end
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    repeat (2) step();
  endtask

  task automatic reset_chk(input string nm);
    @(negedge clk);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid_out"}, valid_out, 0);
    chk({nm, "_errs"}, {err_overrun, err_orphan}, 0);
    chk_t({nm, "_out_seq"}, out_seq, '0);
  endtask

  seq_emb_t x1, x2, f1, f2;
  int o0, v0, c1;

  initial begin
    rst_n = 1'b0; skip_valid = 1'b0; ffn_valid = 1'b0;
    skip_seq = '0; ffn_seq = '0;
    repeat (3) @(posedge clk);
    reset_chk("reset");
    step(); rst_n = 1'b1;

    // x=1, f=2 with ffn five cycles after skip
    txn(fill(16'd1), fill(16'd2), 5, 1'b1);
    drain();

    // simultaneous arrival, x[t][e]=t, f[t][e]=e
    for (int t = 0; t < SEQ; t++)
      for (int e = 0; e < EMB; e++) begin x1[t][e] = elem_t'(t); f1[t][e] = elem_t'(e); end
    txn(x1, f1, 0, 1'b1);
    @(negedge clk); chk("busy_in_add", busy, 1);
    drain();
    chk("busy_after_done", busy, 0);

    // overflow boundaries: even rows 0x7000+0x2000, odd rows 0x8000+0xFFFF
    for (int t = 0; t < SEQ; t++)
      for (int e = 0; e < EMB; e++) begin
        x1[t][e] = t[0] ? 16'h8000 : 16'h7000;
        f1[t][e] = t[0] ? 16'hFFFF : 16'h2000;
      end
    txn(x1, f1, 1, 1'b1);
    drain();

    // orphan ffn in IDLE
    o0 = orphan_cnt; v0 = overrun_cnt;
    step(); ffn_seq = rnd(); ffn_valid = 1'b1;
    step(); ffn_valid = 1'b0;
    repeat (2) step();
    chk("orphan_idle", orphan_cnt - o0, 1);
    chk("orphan_idle_busy", busy, 0);

    // second skip while waiting; late ffn and skip while adding are dropped
    x1 = rnd(); x2 = rnd(); f1 = rnd(); f2 = rnd();
    o0 = orphan_cnt; v0 = overrun_cnt;
    step(); skip_seq = x1; skip_valid = 1'b1;
    step(); skip_seq = x2;
    step(); skip_valid = 1'b0;
    @(negedge clk); chk("busy_wait_ffn", busy, 1);
    step(); ffn_seq = f1; ffn_valid = 1'b1; c1 = cyc;
    q.push_back('{ref_sum(x1, f1), c1 + SEQ + 1});
    step(); ffn_valid = 1'b0;
    step(); ffn_seq = f2; ffn_valid = 1'b1; skip_seq = x2; skip_valid = 1'b1;
    step(); ffn_valid = 1'b0; skip_valid = 1'b0;
    drain();
    chk("overrun_cnt", overrun_cnt - v0, 2);
    chk("orphan_in_add", orphan_cnt - o0, 1);

    // reset halfway through ADD discards the partial result
    txn(rnd(), rnd(), 0, 1'b0);
    repeat (SEQ / 2 - 1) step();
    rst_n = 1'b0;
    reset_chk("midadd_reset");
    step(); rst_n = 1'b1;
    txn(rnd(), rnd(), 2, 1'b1);
    drain();

    // back-to-back: next skip arrives in the valid_out cycle
    o0 = orphan_cnt; v0 = overrun_cnt;
    x1 = rnd(); f1 = rnd(); x2 = rnd(); f2 = rnd();
    step(); skip_seq = x1; ffn_seq = f1; skip_valid = 1'b1; ffn_valid = 1'b1; c1 = cyc;
    q.push_back('{ref_sum(x1, f1), c1 + SEQ + 1});
    step(); skip_valid = 1'b0; ffn_valid = 1'b0;
    repeat (SEQ) step();
    skip_seq = x2; skip_valid = 1'b1;
    step(); skip_valid = 1'b0; ffn_seq = f2; ffn_valid = 1'b1; c1 = cyc;
    q.push_back('{ref_sum(x2, f2), c1 + SEQ + 1});
    step(); ffn_valid = 1'b0;
    drain();
    chk("b2b_errors", (orphan_cnt - o0) + (overrun_cnt - v0), 0);

    // random traffic with random skip-to-ffn gaps
    for (int i = 0; i < 6; i++) begin
      txn(rnd(), rnd(), int'($urandom_range(0, 3)), 1'b1);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
